mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory bus between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV32I pipeline.
- Sequences each bus transaction with a valid/ready handshake, and enforces fixed data-over-instruction priority.
- Generates the structural-hazard stalls: it freezes the pipeline while a data access is pending and holds fetch while an instruction read is pending.
- A watchdog aborts any bus transaction that hangs.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle, serving a data access, or serving an instruction read
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } arbState_t;

    // Which requester owns the bus transaction currently in flight
    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } arbOwner_t;

    // All-ones byte enable pattern; the top module keeps the low DATA_W/8 bits
    localparam logic [63:0] BE_ALL = '1;

    // Width of the watchdog counter, wide enough for the largest timeout
    localparam int WDOG_W = 16;

endpackage

// File: rtl/mem_watchdog.sv
// Bus watchdog: counts stalled busy cycles and flags when the limit is reached.
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Count wait cycles; a new transaction restarts the count from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expire on the wait cycle that would bring the count up to TIMEOUT
    always_comb begin
        expire = enable && (count == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the data
// stage, sequences each bus transfer and produces the pipeline stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                stall_fetch,
    output logic                stall_pipe,
    output logic                bus_err,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arbState_t         state;
    arbState_t         nextState;
    arbOwner_t         busOwner;

    logic              busy;
    logic              dataWant;
    logic              instWant;
    logic              grantD;
    logic              grantI;
    logic              complete;
    logic              abort;
    logic              killFlag;
    logic              killNow;

    logic              busWe;
    logic [BE_W-1:0]   busBe;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busWdata;

    logic              wdClear;
    logic              wdEnable;
    logic              wdExpire;

    // Request qualification, bus ownership and the watchdog controls
    always_comb begin
        busy     = (state != IDLE);
        dataWant = dm_req && !dm_done;
        instWant = if_req && !if_done && !if_kill;
        busOwner = (state == IBUSY) ? OWN_I : OWN_D;
        killNow  = killFlag || if_kill;
        wdClear  = grantD || grantI;
        wdEnable = busy && !mem_ready;
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (WDOG_W)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdClear),
        .enable (wdEnable),
        .expire (wdExpire)
    );

    // State register; reset returns to IDLE even mid-transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Grant with data priority, then wait for the bus handshake or the watchdog
    always_comb begin
        nextState = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (dataWant) begin
                    grantD    = 1'b1;
                    nextState = DBUSY;
                end else if (instWant) begin
                    grantI    = 1'b1;
                    nextState = IBUSY;
                end
            end
            DBUSY, IBUSY: begin
                if (mem_ready) begin
                    complete  = 1'b1;
                    nextState = IDLE;
                end else if (wdExpire) begin
                    abort     = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latch the winning request so the bus stays stable while we wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busWe    <= 1'b0;
            busBe    <= '0;
            busAddr  <= '0;
            busWdata <= '0;
        end else if (grantD) begin
            busWe    <= dm_we;
            busBe    <= dm_be;
            busAddr  <= dm_addr;
            busWdata <= dm_wdata;
        end else if (grantI) begin
            busWe    <= 1'b0;
            busBe    <= BE_ALL[BE_W-1:0];
            busAddr  <= if_addr;
            busWdata <= '0;
        end
    end

    // Bus outputs are only live while a transfer is in flight
    always_comb begin
        mem_valid = busy;
        mem_we    = busy && busWe;
        mem_be    = busy ? busBe    : '0;
        mem_addr  = busy ? busAddr  : '0;
        mem_wdata = busy ? busWdata : '0;
    end

    // Remember a fetch redirect that arrives while the instruction read is out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            killFlag <= 1'b0;
        end else if ((state == IBUSY) && (complete || abort)) begin
            killFlag <= 1'b0;
        end else if ((state == IBUSY) && if_kill) begin
            killFlag <= 1'b1;
        end
    end

    // Finish a transfer: capture read data and pulse done/error for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_done  <= 1'b0;
            if_done  <= 1'b0;
            bus_err  <= 1'b0;
            dm_rdata <= '0;
            if_rdata <= '0;
        end else begin
            dm_done <= 1'b0;
            if_done <= 1'b0;
            bus_err <= 1'b0;
            if (complete || abort) begin
                if (busOwner == OWN_D) begin
                    dm_done  <= 1'b1;
                    bus_err  <= abort;
                    dm_rdata <= complete ? mem_rdata : '0;
                end else if (!killNow) begin
                    if_done  <= 1'b1;
                    bus_err  <= abort;
                    if_rdata <= complete ? mem_rdata : '0;
                end
            end
        end
    end

    // Structural-hazard stalls, straight from the outstanding requests
    always_comb begin
        stall_pipe  = dm_req && !dm_done;
        stall_fetch = stall_pipe || (if_req && !if_done);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_kill = 1'b0;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [BE_W-1:0]   dm_be = '0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall_fetch;
    logic              stall_pipe;
    logic              bus_err;
    logic              mem_valid;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    // Responder controls: >=0 fixed wait states, -1 random 0..3, -2 never ready
    int          waitMode = 0;
    bit          useFixed = 1'b0;
    logic [31:0] fixedData = '0;
    bit          respActive = 1'b0;
    int          waitLeft = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busTxn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } doneTxn_t;

    busTxn_t  dBusQ[$];
    busTxn_t  iBusQ[$];
    doneTxn_t dDoneQ[$];
    doneTxn_t iDoneQ[$];

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_kill     (if_kill),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_be       (dm_be),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_done     (dm_done),
        .dm_rdata    (dm_rdata),
        .stall_fetch (stall_fetch),
        .stall_pipe  (stall_pipe),
        .bus_err     (bus_err),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the bench: a fixed function of the address
    function automatic logic [31:0] memModel(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rdFor(input logic [31:0] a);
        return useFixed ? fixedData : memModel(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) nextCycle();
    endtask

    // Data fetches are tagged by address: fetch region has top nibble 8
    task automatic expectData(input logic [31:0] a, input logic we, input logic [3:0] be,
                              input logic [31:0] wd, input logic err);
        busTxn_t  b;
        doneTxn_t d;
        b.addr = a; b.we = we; b.be = be; b.wdata = wd;
        d.err = err;
        d.rdata = err ? 32'h0 : rdFor(a);
        if (!err) dBusQ.push_back(b);
        dDoneQ.push_back(d);
    endtask

    task automatic expectFetch(input logic [31:0] a, input logic killed);
        busTxn_t  b;
        doneTxn_t d;
        b.addr = a; b.we = 1'b0; b.be = 4'hF; b.wdata = '0;
        d.err = 1'b0;
        d.rdata = rdFor(a);
        iBusQ.push_back(b);
        if (!killed) iDoneQ.push_back(d);
    endtask

    task automatic checkBusBeat();
        busTxn_t e;
        if (mem_addr[31:28] == 4'h8) begin
            if (iBusQ.size() == 0) begin
                failNow("unexpected fetch bus beat");
            end else begin
                e = iBusQ.pop_front();
                checkOutput("fetch mem_addr", mem_addr, e.addr);
                checkOutput("fetch mem_we", {31'b0, mem_we}, 32'd0);
                checkOutput("fetch mem_be", {28'b0, mem_be}, 32'hF);
            end
        end else begin
            if (dBusQ.size() == 0) begin
                failNow("unexpected data bus beat");
            end else begin
                e = dBusQ.pop_front();
                checkOutput("data mem_addr", mem_addr, e.addr);
                checkOutput("data mem_we", {31'b0, mem_we}, {31'b0, e.we});
                checkOutput("data mem_be", {28'b0, mem_be}, {28'b0, e.be});
                if (e.we) checkOutput("data mem_wdata", mem_wdata, e.wdata);
            end
        end
    endtask

    // Bus slave: chooses wait states per transfer and checks each completed beat
    always @(negedge clk) begin
        if (reset || !mem_valid) begin
            mem_ready = 1'b0;
            respActive = 1'b0;
        end else begin
            if (!respActive) begin
                respActive = 1'b1;
                if (waitMode >= 0) waitLeft = waitMode;
                else if (waitMode == -1) waitLeft = $urandom_range(0, 3);
                else waitLeft = 1000000;
            end
            if (waitLeft == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rdFor(mem_addr);
                respActive = 1'b0;
                checkBusBeat();
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                waitLeft--;
            end
        end
    end

    // Completion monitor: pops the scoreboard whenever a done pulse appears
    always @(negedge clk) begin
        doneTxn_t e;
        if (!reset) begin
            if (dm_done) begin
                if (dDoneQ.size() == 0) begin
                    failNow("unexpected dm_done");
                end else begin
                    e = dDoneQ.pop_front();
                    checkOutput("dm_rdata", dm_rdata, e.rdata);
                    checkOutput("dm bus_err", {31'b0, bus_err}, {31'b0, e.err});
                end
            end
            if (if_done) begin
                if (iDoneQ.size() == 0) begin
                    failNow("unexpected if_done");
                end else begin
                    e = iDoneQ.pop_front();
                    checkOutput("if_rdata", if_rdata, e.rdata);
                    checkOutput("if bus_err", {31'b0, bus_err}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_valid"}, {31'b0, mem_valid}, 32'd0);
        checkOutput({tag, " mem_we"}, {31'b0, mem_we}, 32'd0);
        checkOutput({tag, " mem_be"}, {28'b0, mem_be}, 32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, " if_done"}, {31'b0, if_done}, 32'd0);
        checkOutput({tag, " dm_done"}, {31'b0, dm_done}, 32'd0);
        checkOutput({tag, " if_rdata"}, if_rdata, 32'd0);
        checkOutput({tag, " dm_rdata"}, dm_rdata, 32'd0);
        checkOutput({tag, " bus_err"}, {31'b0, bus_err}, 32'd0);
        checkOutput({tag, " stall_pipe"}, {31'b0, stall_pipe}, 32'd0);
        checkOutput({tag, " stall_fetch"}, {31'b0, stall_fetch}, 32'd0);
    endtask

    // Random data-stage requester: hold the request until dm_done, then move on
    task automatic dataTxn();
        logic [31:0] r;
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        int          n;
        r  = $urandom;
        a  = {4'h1, r[27:2], 2'b00};
        we = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(1, 15));
        wd = $urandom;
        dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = a; dm_wdata = wd;
        expectData(a, we, be, wd, 1'b0);
        n = 0;
        do begin
            nextCycle();
            n++;
        end while (!dm_done && n < 60);
        if (!dm_done) failNow("dm_done wait budget expired");
        nextCycle();
        dm_req = 1'b0;
    endtask

    // Random fetch requester: same handshake on the instruction side
    task automatic fetchTxn();
        logic [31:0] r;
        logic [31:0] a;
        int          n;
        r = $urandom;
        a = {4'h8, r[27:2], 2'b00};
        if_req = 1'b1; if_addr = a;
        expectFetch(a, 1'b0);
        n = 0;
        do begin
            nextCycle();
            n++;
        end while (!if_done && n < 60);
        if (!if_done) failNow("if_done wait budget expired");
        nextCycle();
        if_req = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset state, while reset is held
        idleCycles(2);
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Zero-wait load
        nextCycle();
        useFixed = 1'b1; fixedData = 32'hDEAD_BEEF; waitMode = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = '0;
        expectData(32'h100, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("zw c0 stall_pipe", {31'b0, stall_pipe}, 32'd1);
        checkOutput("zw c0 mem_valid", {31'b0, mem_valid}, 32'd0);
        nextCycle(); @(negedge clk);
        checkOutput("zw c1 mem_valid", {31'b0, mem_valid}, 32'd1);
        checkOutput("zw c1 mem_addr", mem_addr, 32'h100);
        checkOutput("zw c1 stall_pipe", {31'b0, stall_pipe}, 32'd1);
        nextCycle(); @(negedge clk);
        checkOutput("zw c2 dm_done", {31'b0, dm_done}, 32'd1);
        checkOutput("zw c2 dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        checkOutput("zw c2 stall_pipe", {31'b0, stall_pipe}, 32'd0);
        nextCycle();
        dm_req = 1'b0; useFixed = 1'b0;
        idleCycles(1);

        // Contention: store and fetch rise together, data goes first
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h200; dm_wdata = 32'h1234;
        if_req = 1'b1; if_addr = 32'h8000_0040;
        expectData(32'h200, 1'b1, 4'h3, 32'h1234, 1'b0);
        expectFetch(32'h8000_0040, 1'b0);
        @(negedge clk);
        checkOutput("ct c0 stall_fetch", {31'b0, stall_fetch}, 32'd1);
        nextCycle(); @(negedge clk);
        checkOutput("ct c1 mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("ct c1 mem_be", {28'b0, mem_be}, 32'h3);
        checkOutput("ct c1 stall_fetch", {31'b0, stall_fetch}, 32'd1);
        nextCycle(); @(negedge clk);
        checkOutput("ct c2 dm_done", {31'b0, dm_done}, 32'd1);
        checkOutput("ct c2 stall_fetch", {31'b0, stall_fetch}, 32'd1);
        nextCycle();
        dm_req = 1'b0;
        @(negedge clk);
        checkOutput("ct c3 mem_valid", {31'b0, mem_valid}, 32'd1);
        checkOutput("ct c3 mem_addr", mem_addr, 32'h8000_0040);
        checkOutput("ct c3 stall_fetch", {31'b0, stall_fetch}, 32'd1);
        nextCycle(); @(negedge clk);
        checkOutput("ct c4 if_done", {31'b0, if_done}, 32'd1);
        checkOutput("ct c4 stall_fetch", {31'b0, stall_fetch}, 32'd0);
        nextCycle();
        if_req = 1'b0;
        idleCycles(1);

        // Three wait states: bus held stable for four valid cycles
        waitMode = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hC; dm_addr = 32'h300; dm_wdata = 32'hCAFE_0001;
        expectData(32'h300, 1'b1, 4'hC, 32'hCAFE_0001, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            nextCycle(); @(negedge clk);
            checkOutput($sformatf("ws c%0d mem_valid", i), {31'b0, mem_valid}, 32'd1);
            checkOutput($sformatf("ws c%0d mem_addr", i), mem_addr, 32'h300);
            checkOutput($sformatf("ws c%0d mem_wdata", i), mem_wdata, 32'hCAFE_0001);
            checkOutput($sformatf("ws c%0d mem_be", i), {28'b0, mem_be}, 32'hC);
        end
        nextCycle(); @(negedge clk);
        checkOutput("ws c5 dm_done", {31'b0, dm_done}, 32'd1);
        nextCycle();
        dm_req = 1'b0;
        idleCycles(1);

        // Preload if_rdata with a known instruction
        waitMode = 0; useFixed = 1'b1; fixedData = 32'h1111_2222;
        if_req = 1'b1; if_addr = 32'h8000_0010;
        expectFetch(32'h8000_0010, 1'b0);
        nextCycle(); nextCycle(); @(negedge clk);
        checkOutput("pre if_done", {31'b0, if_done}, 32'd1);
        nextCycle();
        if_req = 1'b0;
        idleCycles(1);

        // Kill during an instruction read: bus finishes, result discarded
        waitMode = 2; fixedData = 32'h9999_9999;
        if_req = 1'b1; if_addr = 32'h8000_0080;
        expectFetch(32'h8000_0080, 1'b1);
        nextCycle();
        if_kill = 1'b1;
        @(negedge clk);
        checkOutput("kl c1 mem_valid", {31'b0, mem_valid}, 32'd1);
        nextCycle();
        if_kill = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checkOutput("kl c2 mem_valid", {31'b0, mem_valid}, 32'd1);
        nextCycle(); nextCycle(); @(negedge clk);
        checkOutput("kl c4 if_done", {31'b0, if_done}, 32'd0);
        checkOutput("kl c4 if_rdata", if_rdata, 32'h1111_2222);
        checkOutput("kl c4 mem_valid", {31'b0, mem_valid}, 32'd0);
        nextCycle(); @(negedge clk);
        checkOutput("kl c5 if_done", {31'b0, if_done}, 32'd0);
        useFixed = 1'b0;
        idleCycles(1);

        // Watchdog timeout on a load that never gets mem_ready
        waitMode = -2;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h400; dm_wdata = '0;
        expectData(32'h400, 1'b0, 4'hF, 32'h0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            nextCycle(); @(negedge clk);
            checkOutput($sformatf("to c%0d mem_valid", i), {31'b0, mem_valid}, 32'd1);
        end
        nextCycle(); @(negedge clk);
        checkOutput("to c5 mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("to c5 dm_done", {31'b0, dm_done}, 32'd1);
        checkOutput("to c5 bus_err", {31'b0, bus_err}, 32'd1);
        checkOutput("to c5 dm_rdata", dm_rdata, 32'd0);
        nextCycle();
        dm_req = 1'b0;
        idleCycles(1);

        // Asynchronous reset in the middle of a data transfer
        dm_req = 1'b1; dm_addr = 32'h500;
        nextCycle(); @(negedge clk);
        checkOutput("rs busy mem_valid", {31'b0, mem_valid}, 32'd1);
        #2 reset = 1'b1;
        #1 checkOutput("rs async mem_valid", {31'b0, mem_valid}, 32'd0);
        dm_req = 1'b0;
        idleCycles(2);
        @(negedge clk);
        reset = 1'b0;
        waitMode = -1;
        @(negedge clk);
        checkAllZero("post-reset");
    endtask

    task automatic checkOutputQueues();
        checkOutput("dBusQ drained", 32'(dBusQ.size()), 32'd0);
        checkOutput("iBusQ drained", 32'(iBusQ.size()), 32'd0);
        checkOutput("dDoneQ drained", 32'(dDoneQ.size()), 32'd0);
        checkOutput("iDoneQ drained", 32'(iDoneQ.size()), 32'd0);
    endtask

    initial begin
        applyStimulus();
        nextCycle();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idleCycles($urandom_range(0, 2));
                    dataTxn();
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    idleCycles($urandom_range(0, 2));
                    fetchTxn();
                end
            end
        join
        idleCycles(5);
        checkOutputQueues();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
